sim_uart_tx: RTL and testbench

//  Downstream consumer of the data RAM's simulated-UART port (char + 1-cycle valid pulse on store to 0x10000000).

---
 rtl/sim_uart_tx.sv | 221 ++++++++++++++++++++++
 tb/tb_sim_uart_tx.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sim_uart_tx.sv
// Serialiser for the data RAM's simulated-UART port: buffers characters and sends 8N1 frames, LSB first.
// Define SIM_UART_PARITY_EN to insert an even-parity bit (8E1 frames).
module sim_uart_tx #(
  parameter int unsigned CLK_HZ     = 100_000_000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [7:0]                    char_in,
  input  logic                          char_valid,
  output logic                          tx,
  output logic                          busy,
  output logic                          fifo_full,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);

  localparam int unsigned DIV = CLK_HZ / BAUD;
  localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned NW  = AW + 1;

  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
  localparam logic [NW-1:0] DEPTH_N  = NW'(FIFO_DEPTH);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] STOP   = 3'd3;
`ifdef SIM_UART_PARITY_EN
  localparam logic [2:0] PARITY = 3'd4;
`endif

  // ---------------------------------------------------------------------------
  // Character FIFO
  // ---------------------------------------------------------------------------
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [NW-1:0] count_q;
  logic          ovf_q;

  logic          fifo_nempty;
  logic          bit_done;
  logic          pop;
  logic          push;
  logic          drop;
  logic [7:0]    head;

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
`ifdef SIM_UART_PARITY_EN
  logic          parity_q, parity_d;
`endif

  assign fifo_nempty = (count_q != '0);
  assign bit_done    = (cnt_q == CNT_LAST);
  assign head        = mem_q[rd_ptr_q];

  // A pop happens only when the line takes a new frame: from IDLE, or straight out of STOP.
  assign pop  = fifo_nempty && ((state_q == IDLE) || ((state_q == STOP) && bit_done));
  // A full FIFO still accepts a push on the same edge that frees a slot.
  assign push = char_valid && ((count_q != DEPTH_N) || pop);
  assign drop = char_valid && !push;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (drop) ovf_q <= 1'b1;
    end
  end

  // NOTE: the storage array has no reset; entries are only read behind a non-zero count.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= char_in;
  end

  // ---------------------------------------------------------------------------
  // Frame FSM
  // ---------------------------------------------------------------------------
  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
`ifdef SIM_UART_PARITY_EN
    parity_d  = parity_q;
`endif

    unique case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (pop) begin
          state_d = START;
          cnt_d   = '0;
          tx_d    = 1'b0;
          shift_d = head;
`ifdef SIM_UART_PARITY_EN
          parity_d = ^head;
`endif
        end
      end

      START: begin
        if (bit_done) begin
          state_d   = DATA;
          cnt_d     = '0;
          bit_idx_d = 3'd0;
          tx_d      = shift_q[0];
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      DATA: begin
        if (bit_done) begin
          cnt_d   = '0;
          shift_d = shift_q >> 1;
          if (bit_idx_q == 3'd7) begin
`ifdef SIM_UART_PARITY_EN
            state_d = PARITY;
            tx_d    = parity_q;
`else
            state_d = STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            tx_d      = shift_q[1];
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

`ifdef SIM_UART_PARITY_EN
      PARITY: begin
        if (bit_done) begin
          state_d = STOP;
          cnt_d   = '0;
          tx_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif

      STOP: begin
        if (bit_done) begin
          cnt_d = '0;
          // Chain straight into the next start bit so queued text leaves no idle gap.
          if (pop) begin
            state_d = START;
            tx_d    = 1'b0;
            shift_d = head;
`ifdef SIM_UART_PARITY_EN
            parity_d = ^head;
`endif
          end else begin
            state_d = IDLE;
            tx_d    = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'h00;
      tx_q      <= 1'b1;
`ifdef SIM_UART_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
`ifdef SIM_UART_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  assign tx         = tx_q;
  assign busy       = (state_q != IDLE) || fifo_nempty;
  assign fifo_full  = (count_q == DEPTH_N);
  assign fifo_count = count_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_sim_uart_tx.sv
// Directed bench for sim_uart_tx with DIV=10 and a 4-entry FIFO; samples the line mid-bit to recover bytes.
// Build with SIM_UART_PARITY_EN defined to exercise the 8E1 frame.
module tb_sim_uart_tx;

  localparam int CLK_HZ = 100;
  localparam int BAUD   = 10;
  localparam int DEPTH  = 4;
  localparam int DIV    = CLK_HZ / BAUD;
`ifdef SIM_UART_PARITY_EN
  localparam int FRAME  = 11 * DIV;
`else
  localparam int FRAME  = 10 * DIV;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] char_in;
  logic       char_valid;
  logic       tx;
  logic       busy;
  logic       fifo_full;
  logic [2:0] fifo_count;
  logic       overflow;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int last_fall = 0;
  logic tx_prev = 1'b1;

  sim_uart_tx #(
    .CLK_HZ    (CLK_HZ),
    .BAUD      (BAUD),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .char_in   (char_in),
    .char_valid(char_valid),
    .tx        (tx),
    .busy      (busy),
    .fifo_full (fifo_full),
    .fifo_count(fifo_count),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Records the edge number on which the line last fell (start of a frame).
  always @(negedge clk) begin
    tx_prev <= tx;
    if (tx_prev && !tx) last_fall <= cyc;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic push(input logic [7:0] c);
    char_in    = c;
    char_valid = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_cyc(input int target);
    int guard;
    guard = 0;
    while (cyc < target && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
  endtask

  task automatic rx_frame(output logic [7:0] data, output logic par, output int fall);
    int guard;
    guard = 0;
    data  = 8'h00;
    par   = 1'b0;
    fall  = 0;
    while (tx !== 1'b0 && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    if (tx !== 1'b0) begin
      check("rx_timeout", 32'd1, 32'd0);
      return;
    end
    #1;
    fall = last_fall;
    wait_cyc(fall + DIV / 2);
    check("rx_start", {31'd0, tx}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      wait_cyc(fall + DIV / 2 + DIV * (i + 1));
      data[i] = tx;
    end
`ifdef SIM_UART_PARITY_EN
    wait_cyc(fall + DIV / 2 + 9 * DIV);
    par = tx;
    check("rx_parity", {31'd0, par}, {31'd0, ^data});
    wait_cyc(fall + DIV / 2 + 10 * DIV);
`else
    wait_cyc(fall + DIV / 2 + 9 * DIV);
`endif
    check("rx_stop", {31'd0, tx}, 32'd1);
  endtask

  function automatic logic exp_line(input int d, input logic [7:0] b);
    if (d <= DIV)          return 1'b0;
    else if (d <= 9 * DIV) return b[(d - DIV - 1) / DIV];
`ifdef SIM_UART_PARITY_EN
    else if (d <= 10 * DIV) return ^b;
`endif
    else                   return 1'b1;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] b;
    logic       p;
    int         f1, f2, e0;
    logic [7:0] exp_q [$];

    rst_n      = 1'b0;
    char_valid = 1'b0;
    char_in    = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_tx", {31'd0, tx}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_count", {29'd0, fifo_count}, 32'd0);
    check("rst_full", {31'd0, fifo_full}, 32'd0);
    check("rst_ovf", {31'd0, overflow}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("post_rst_tx", {31'd0, tx}, 32'd1);

    // Single 0x55, checked on every edge of the frame.
    push(8'h55);
    char_valid = 1'b0;
    e0 = cyc;
    check("t2_tx_e0", {31'd0, tx}, 32'd1);
    check("t2_count_e0", {29'd0, fifo_count}, 32'd1);
    check("t2_busy_e0", {31'd0, busy}, 32'd1);
    for (int k = 1; k <= FRAME + 1; k++) begin
      @(negedge clk);
      check("t2_line", {31'd0, tx}, {31'd0, exp_line(cyc - e0, 8'h55)});
      check("t2_busy", {31'd0, busy}, (cyc - e0 <= FRAME) ? 32'd1 : 32'd0);
      if (k == 1) check("t2_count_e1", {29'd0, fifo_count}, 32'd0);
    end

    // Back-to-back frames.
    push(8'h41);
    push(8'h42);
    char_valid = 1'b0;
    rx_frame(b, p, f1);
    check("t3_byte0", {24'd0, b}, 32'h41);
    rx_frame(b, p, f2);
    check("t3_byte1", {24'd0, b}, 32'h42);
    check("t3_gap", f2 - f1, FRAME);
    wait_cyc(f2 + FRAME - 1);
    check("t3_busy_end", {31'd0, busy}, 32'd1);
    wait_cyc(f2 + FRAME);
    check("t3_busy_idle", {31'd0, busy}, 32'd0);

    // Overflow: six pushes into a 4-deep FIFO while the first frame starts.
    for (int i = 0; i < 6; i++) push(8'h31 + 8'(i));
    char_valid = 1'b0;
    check("t4_count", {29'd0, fifo_count}, 32'd4);
    check("t4_full", {31'd0, fifo_full}, 32'd1);
    check("t4_ovf", {31'd0, overflow}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      rx_frame(b, p, f1);
      check("t4_byte", {24'd0, b}, 32'h31 + i);
    end
    wait_cyc(f1 + FRAME);
    check("t4_busy_idle", {31'd0, busy}, 32'd0);
    check("t4_ovf_sticky", {31'd0, overflow}, 32'd1);

    // Reset mid-frame, with char_valid held during reset.
    push(8'h5A);
    push(8'h5B);
    char_valid = 1'b0;
    repeat (30) @(negedge clk);
    check("t1_busy_pre", {31'd0, busy}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t1_tx", {31'd0, tx}, 32'd1);
    check("t1_busy", {31'd0, busy}, 32'd0);
    check("t1_count", {29'd0, fifo_count}, 32'd0);
    check("t1_ovf", {31'd0, overflow}, 32'd0);
    @(negedge clk);
    push(8'h77);
    push(8'h78);
    char_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check("t1_count_rel", {29'd0, fifo_count}, 32'd0);
    check("t1_tx_rel", {31'd0, tx}, 32'd1);

    // Full FIFO accepting a push on the STOP->START pop edge.
    push(8'h11);
    for (int i = 0; i < 4; i++) push(8'h21 + 8'(i));
    char_valid = 1'b0;
    f1 = last_fall;
    check("t5_count_full", {29'd0, fifo_count}, 32'd4);
    check("t5_full", {31'd0, fifo_full}, 32'd1);
    wait_cyc(f1 + FRAME - 1);
    push(8'h25);
    char_valid = 1'b0;
    check("t5_count", {29'd0, fifo_count}, 32'd4);
    check("t5_ovf", {31'd0, overflow}, 32'd0);
    check("t5_tx_start", {31'd0, tx}, 32'd0);
    for (int i = 0; i < 5; i++) exp_q.push_back(8'h21 + 8'(i));
    while (exp_q.size() > 0) begin
      rx_frame(b, p, f1);
      check("t5_byte", {24'd0, b}, {24'd0, exp_q.pop_front()});
    end
    wait_cyc(f1 + FRAME);
    check("t5_busy_idle", {31'd0, busy}, 32'd0);
    check("t5_ovf_end", {31'd0, overflow}, 32'd0);

`ifdef SIM_UART_PARITY_EN
    // Even parity: 0x07 has three ones, 0x03 has two.
    push(8'h07);
    char_valid = 1'b0;
    rx_frame(b, p, f1);
    check("t6_byte07", {24'd0, b}, 32'h07);
    check("t6_par07", {31'd0, p}, 32'd1);
    wait_cyc(f1 + 110 - 1);
    check("t6_busy_end", {31'd0, busy}, 32'd1);
    wait_cyc(f1 + 110);
    check("t6_busy_idle", {31'd0, busy}, 32'd0);
    push(8'h03);
    char_valid = 1'b0;
    rx_frame(b, p, f1);
    check("t6_byte03", {24'd0, b}, 32'h03);
    check("t6_par03", {31'd0, p}, 32'd0);
    wait_cyc(f1 + FRAME);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
